// File: rtl/regstatus_file.sv
// Register status file: 32 architectural registers with busy/ROB-tag
// tracking, dual commit ports, dual rename slots, flush recovery and four
// combinational read ports with same-cycle commit bypass.

// One read port: register lookup plus bypass from an in-flight commit
// whose tag matches the pending rename of the read register.
module regstatus_rdport #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 32
) (
  input  logic                            rstN,
  input  logic [4:0]                      ra,
  input  logic [31:0][DATA_WIDTH-1:0]     dataQ,
  input  logic [31:0]                     busyQ,
  input  logic [31:0][TAG_WIDTH-1:0]      tagQ,
  input  logic                            we1,
  input  logic [4:0]                      wa1,
  input  logic [DATA_WIDTH-1:0]           wd1,
  input  logic [TAG_WIDTH-1:0]            wd1Tag,
  input  logic                            we2,
  input  logic [4:0]                      wa2,
  input  logic [DATA_WIDTH-1:0]           wd2,
  input  logic [TAG_WIDTH-1:0]            wd2Tag,
  output logic [DATA_WIDTH-1:0]           rd,
  output logic                            rBusy,
  output logic [TAG_WIDTH-1:0]            rTag
);
  logic hit1, hit2;

  // Lookup with bypass; port 2 is the younger commit so it wins.
  always_comb begin
    hit1  = we1 && (wa1 == ra) && (ra != 5'd0) && busyQ[ra] && (tagQ[ra] == wd1Tag);
    hit2  = we2 && (wa2 == ra) && (ra != 5'd0) && busyQ[ra] && (tagQ[ra] == wd2Tag);
    rd    = dataQ[ra];
    rBusy = busyQ[ra];
    rTag  = busyQ[ra] ? tagQ[ra] : '0;
    if (hit2) begin
      rd = wd2; rBusy = 1'b0; rTag = '0;
    end else if (hit1) begin
      rd = wd1; rBusy = 1'b0; rTag = '0;
    end
    // Inputs must not leak through the bypass while held in reset.
    if (!rstN) begin
      rd = '0; rBusy = 1'b0; rTag = '0;
    end
  end
endmodule

module regstatus_file #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 32
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic                  RegFileWE1,
  input  logic                  RegFileWE2,
  input  logic [4:0]            RegFileWA1,
  input  logic [4:0]            RegFileWA2,
  input  logic [DATA_WIDTH-1:0] RegFileWD1,
  input  logic [DATA_WIDTH-1:0] RegFileWD2,
  input  logic [TAG_WIDTH-1:0]  RegFileWD1Tag,
  input  logic [TAG_WIDTH-1:0]  RegFileWD2Tag,
  input  logic                  RenWE0,
  input  logic                  RenWE1,
  input  logic [4:0]            RenWA0,
  input  logic [4:0]            RenWA1,
  input  logic [TAG_WIDTH-1:0]  RenTag0,
  input  logic [TAG_WIDTH-1:0]  RenTag1,
  input  logic                  Flush,
  input  logic [4:0]            RA0,
  input  logic [4:0]            RA1,
  input  logic [4:0]            RA2,
  input  logic [4:0]            RA3,
  output logic [DATA_WIDTH-1:0] RD0,
  output logic [DATA_WIDTH-1:0] RD1,
  output logic [DATA_WIDTH-1:0] RD2,
  output logic [DATA_WIDTH-1:0] RD3,
  output logic                  RBusy0,
  output logic                  RBusy1,
  output logic                  RBusy2,
  output logic                  RBusy3,
  output logic [TAG_WIDTH-1:0]  RTag0,
  output logic [TAG_WIDTH-1:0]  RTag1,
  output logic [TAG_WIDTH-1:0]  RTag2,
  output logic [TAG_WIDTH-1:0]  RTag3,
  output logic [5:0]            BusyCount,
  output logic [31:0]           CommitCount
);
  localparam int NUM_LANES = 4;

  logic [31:0][DATA_WIDTH-1:0] dataQ;
  logic [31:0]                 busyQ, busyN;
  logic [31:0][TAG_WIDTH-1:0]  tagQ, tagN;
  logic [5:0]                  popN;
  logic                        cm1, cm2;

  logic [NUM_LANES-1:0][4:0]            raV;
  logic [NUM_LANES-1:0][DATA_WIDTH-1:0] rdV;
  logic [NUM_LANES-1:0]                 rBusyV;
  logic [NUM_LANES-1:0][TAG_WIDTH-1:0]  rTagV;

  assign cm1 = RegFileWE1 && (RegFileWA1 != 5'd0);
  assign cm2 = RegFileWE2 && (RegFileWA2 != 5'd0);

  // Next busy/tag: matching commits retire, then flush or renames apply,
  // so a same-cycle rename always leaves the register busy.
  always_comb begin
    busyN = busyQ;
    tagN  = tagQ;
    if (cm1 && busyQ[RegFileWA1] && (tagQ[RegFileWA1] == RegFileWD1Tag)) begin
      busyN[RegFileWA1] = 1'b0;
      tagN[RegFileWA1]  = '0;
    end
    if (cm2 && busyQ[RegFileWA2] && (tagQ[RegFileWA2] == RegFileWD2Tag)) begin
      busyN[RegFileWA2] = 1'b0;
      tagN[RegFileWA2]  = '0;
    end
    if (Flush) begin
      busyN = '0;
      tagN  = '0;
    end else begin
      if (RenWE0 && (RenWA0 != 5'd0)) begin
        busyN[RenWA0] = 1'b1;
        tagN[RenWA0]  = RenTag0;
      end
      if (RenWE1 && (RenWA1 != 5'd0)) begin
        busyN[RenWA1] = 1'b1;
        tagN[RenWA1]  = RenTag1;
      end
    end
  end

  // Popcount of the next busy vector feeds the registered BusyCount.
  always_comb begin
    popN = '0;
    for (int i = 0; i < 32; i++) popN = popN + {5'd0, busyN[i]};
  end

  // State update; port 2 data assignment lands last so it wins ties.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      dataQ       <= '0;
      busyQ       <= '0;
      tagQ        <= '0;
      BusyCount   <= '0;
      CommitCount <= '0;
    end else begin
      if (cm1) dataQ[RegFileWA1] <= RegFileWD1;
      if (cm2) dataQ[RegFileWA2] <= RegFileWD2;
      busyQ       <= busyN;
      tagQ        <= tagN;
      BusyCount   <= popN;
      CommitCount <= CommitCount + {30'd0, cm1} + {30'd0, cm2};
    end
  end

  assign raV = {RA3, RA2, RA1, RA0};

  for (genvar k = 0; k < NUM_LANES; k++) begin : gRd
    regstatus_rdport #(.DATA_WIDTH(DATA_WIDTH), .TAG_WIDTH(TAG_WIDTH)) uRd (
      .rstN(Reset), .ra(raV[k]), .dataQ(dataQ), .busyQ(busyQ), .tagQ(tagQ),
      .we1(RegFileWE1), .wa1(RegFileWA1), .wd1(RegFileWD1), .wd1Tag(RegFileWD1Tag),
      .we2(RegFileWE2), .wa2(RegFileWA2), .wd2(RegFileWD2), .wd2Tag(RegFileWD2Tag),
      .rd(rdV[k]), .rBusy(rBusyV[k]), .rTag(rTagV[k])
    );
  end

  assign {RD3, RD2, RD1, RD0}         = rdV;
  assign {RBusy3, RBusy2, RBusy1, RBusy0} = rBusyV;
  assign {RTag3, RTag2, RTag1, RTag0}     = rTagV;
endmodule

// File: tb/tb_regstatus_file.sv
// Scoreboard bench for regstatus_file: stimulus pushes expected read-port
// and counter values; a negedge monitor pops and compares them.
module tb_regstatus_file;
  logic        CLK = 1'b0, Reset = 1'b0;
  logic        RegFileWE1, RegFileWE2, RenWE0, RenWE1, Flush;
  logic [4:0]  RegFileWA1, RegFileWA2, RenWA0, RenWA1, RA0, RA1, RA2, RA3;
  logic [31:0] RegFileWD1, RegFileWD2, RegFileWD1Tag, RegFileWD2Tag, RenTag0, RenTag1;
  logic [31:0] RD0, RD1, RD2, RD3, RTag0, RTag1, RTag2, RTag3, CommitCount;
  logic        RBusy0, RBusy1, RBusy2, RBusy3;
  logic [5:0]  BusyCount;

  regstatus_file #(.DATA_WIDTH(32), .TAG_WIDTH(32)) dut (
    .CLK(CLK), .Reset(Reset),
    .RegFileWE1(RegFileWE1), .RegFileWE2(RegFileWE2),
    .RegFileWA1(RegFileWA1), .RegFileWA2(RegFileWA2),
    .RegFileWD1(RegFileWD1), .RegFileWD2(RegFileWD2),
    .RegFileWD1Tag(RegFileWD1Tag), .RegFileWD2Tag(RegFileWD2Tag),
    .RenWE0(RenWE0), .RenWE1(RenWE1), .RenWA0(RenWA0), .RenWA1(RenWA1),
    .RenTag0(RenTag0), .RenTag1(RenTag1), .Flush(Flush),
    .RA0(RA0), .RA1(RA1), .RA2(RA2), .RA3(RA3),
    .RD0(RD0), .RD1(RD1), .RD2(RD2), .RD3(RD3),
    .RBusy0(RBusy0), .RBusy1(RBusy1), .RBusy2(RBusy2), .RBusy3(RBusy3),
    .RTag0(RTag0), .RTag1(RTag1), .RTag2(RTag2), .RTag3(RTag3),
    .BusyCount(BusyCount), .CommitCount(CommitCount)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       nm;
    int          port;
    logic [31:0] rd;
    logic        busy;
    logic [31:0] tag;
    logic [5:0]  bc;
    logic [31:0] cc;
  } exp_t;

  exp_t q[$];
  int   errors = 0, checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, req);
    end
  endtask

  // Monitor: every negedge, compare all expectations queued this cycle.
  initial begin
    forever begin
      @(negedge CLK);
      while (q.size() > 0) begin
        exp_t e;
        logic [31:0] rd, tg;
        logic bs;
        e = q.pop_front();
        case (e.port)
          0: begin rd = RD0; bs = RBusy0; tg = RTag0; end
          1: begin rd = RD1; bs = RBusy1; tg = RTag1; end
          2: begin rd = RD2; bs = RBusy2; tg = RTag2; end
          default: begin rd = RD3; bs = RBusy3; tg = RTag3; end
        endcase
        chk({e.nm, ".rd"},   rd, e.rd);
        chk({e.nm, ".busy"}, {31'd0, bs}, {31'd0, e.busy});
        chk({e.nm, ".tag"},  tg, e.tag);
        chk({e.nm, ".bc"},   {26'd0, BusyCount}, {26'd0, e.bc});
        chk({e.nm, ".cc"},   CommitCount, e.cc);
      end
    end
  end

  task automatic expect_rd(input string nm, input int port, input logic [31:0] rd,
                           input logic busy, input logic [31:0] tag,
                           input logic [5:0] bc, input logic [31:0] cc);
    exp_t e;
    e.nm = nm; e.port = port; e.rd = rd; e.busy = busy; e.tag = tag; e.bc = bc; e.cc = cc;
    q.push_back(e);
  endtask

  // Advance past a posedge and return every stimulus input to idle.
  task automatic step();
    @(posedge CLK); #1;
    RegFileWE1 = 0; RegFileWE2 = 0; RenWE0 = 0; RenWE1 = 0; Flush = 0;
    RegFileWA1 = 0; RegFileWA2 = 0; RenWA0 = 0; RenWA1 = 0;
    RegFileWD1 = 0; RegFileWD2 = 0; RegFileWD1Tag = 0; RegFileWD2Tag = 0;
    RenTag0 = 0; RenTag1 = 0;
  endtask

  task automatic commit1(input logic [4:0] a, input logic [31:0] d, input logic [31:0] t);
    RegFileWE1 = 1; RegFileWA1 = a; RegFileWD1 = d; RegFileWD1Tag = t;
  endtask
  task automatic commit2(input logic [4:0] a, input logic [31:0] d, input logic [31:0] t);
    RegFileWE2 = 1; RegFileWA2 = a; RegFileWD2 = d; RegFileWD2Tag = t;
  endtask
  task automatic ren0(input logic [4:0] a, input logic [31:0] t);
    RenWE0 = 1; RenWA0 = a; RenTag0 = t;
  endtask
  task automatic ren1(input logic [4:0] a, input logic [31:0] t);
    RenWE1 = 1; RenWA1 = a; RenTag1 = t;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  initial begin
    RA0 = 0; RA1 = 0; RA2 = 0; RA3 = 0;
    step();
    RA0 = 5;
    expect_rd("reset", 0, 0, 0, 0, 0, 0);
    step(); step();
    Reset = 1;

    // rename r5/7, then matching commit bypasses and retires
    step(); ren0(5, 7);                    expect_rd("ren5", 0, 0, 0, 0, 0, 0);
    step(); commit1(5, 32'hDEADBEEF, 7);   expect_rd("byp5", 0, 32'hDEADBEEF, 0, 0, 1, 0);
    step();                                expect_rd("ret5", 0, 32'hDEADBEEF, 0, 0, 0, 1);
    // younger rename survives an older-tag commit
    step(); ren0(5, 7);                    expect_rd("r5a", 0, 32'hDEADBEEF, 0, 0, 0, 1);
    step(); ren0(5, 9);                    expect_rd("r5b", 0, 32'hDEADBEEF, 1, 7, 1, 1);
    step(); commit1(5, 32'h11, 7);         expect_rd("stale", 0, 32'hDEADBEEF, 1, 9, 1, 1);
    step();                                expect_rd("keep9", 0, 32'h11, 1, 9, 1, 2);
    // dual commit same register, port 2 data wins
    step(); RA1 = 3; commit1(3, 32'hA, 0); commit2(3, 32'hB, 0);
                                           expect_rd("dual0", 1, 0, 0, 0, 1, 2);
    step();                                expect_rd("dual1", 1, 32'hB, 0, 0, 1, 4);
    // retire r5 via bypass while renaming r1,r2
    step(); RA2 = 1; commit1(5, 32'h22, 9); ren0(1, 1); ren1(2, 2);
                                           expect_rd("byp5b", 0, 32'h22, 0, 0, 1, 4);
    step(); RA3 = 4; ren0(3, 3); ren1(4, 4);
                                           expect_rd("r1bsy", 2, 0, 1, 1, 2, 5);
    // flush: renames ignored, commits still write
    step(); Flush = 1; ren0(6, 6); commit1(1, 32'h55, 1);
                                           expect_rd("flbyp", 2, 32'h55, 0, 0, 4, 5);
                                           expect_rd("flr4", 3, 0, 1, 4, 4, 5);
    step(); RA0 = 6;                       expect_rd("fl_r1", 2, 32'h55, 0, 0, 0, 6);
                                           expect_rd("fl_r4", 3, 0, 0, 0, 0, 6);
                                           expect_rd("fl_r6", 0, 0, 0, 0, 0, 6);
    // r0 ignores commit and rename
    step(); RA0 = 0; commit1(0, 32'h99, 0); ren0(0, 5);
                                           expect_rd("r0a", 0, 0, 0, 0, 0, 6);
    step();                                expect_rd("r0b", 0, 0, 0, 0, 0, 6);
    // commit and rename same register same cycle
    step(); RA1 = 7; ren0(7, 3);           expect_rd("r7a", 1, 0, 0, 0, 0, 6);
    step(); commit1(7, 32'h77, 3); ren1(7, 8);
                                           expect_rd("r7b", 1, 32'h77, 0, 0, 1, 6);
    step();                                expect_rd("r7c", 1, 32'h77, 1, 8, 1, 7);
    // both rename slots same register, slot 1 tag wins
    step(); RA3 = 9; ren0(9, 1); ren1(9, 2);
                                           expect_rd("r9a", 3, 0, 0, 0, 1, 7);
    step();                                expect_rd("r9b", 3, 0, 1, 2, 2, 7);
    // async reset pulse mid-cycle while r8 busy with a commit in flight
    step(); RA0 = 8; ren0(8, 4);           expect_rd("r8a", 0, 0, 0, 0, 2, 7);
    step();                                expect_rd("r8b", 0, 0, 1, 4, 3, 7);
    step(); commit1(8, 32'hCC, 4); Reset = 0;
                                           expect_rd("rst8", 0, 0, 0, 0, 0, 0);
                                           expect_rd("rst7", 1, 0, 0, 0, 0, 0);
    @(negedge CLK); #1;
    RegFileWE1 = 0; Reset = 1;
    step();                                expect_rd("post8", 0, 0, 0, 0, 0, 0);
                                           expect_rd("post7", 1, 0, 0, 0, 0, 0);
    step(); step();
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
